// File: rtl/fpu_pkg.sv
// Shared FPU types: multiplier flag set, stored product layout and binary32 constants.
package fpu_pkg;

  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
  } fmul_flags_t;

  // Tag width is a per-instance parameter, so the buffer wraps this with its tag.
  typedef struct packed {
    logic [31:0] result;
    fmul_flags_t flags;
  } fmul_prod_t;

endpackage

// File: rtl/fmul_flag_classify.sv
// Combinational flag classification of a multiplier product.
// With FMUL_NAN_CANON_EN defined, NaN products are replaced by the canonical quiet NaN.
module fmul_flag_classify
  import fpu_pkg::*;
(
  input  logic [31:0] in_result,
  input  logic        in_overflow,
  input  logic        in_underflow,
  output fmul_flags_t flags,
  output logic [31:0] result
);

  always_comb begin
    flags.nv = (in_result[30:23] == FP32_EXP_MAX) && (in_result[22:0] != 23'd0);
    flags.of = in_overflow;
    flags.uf = in_underflow;
`ifdef FMUL_NAN_CANON_EN
    result   = flags.nv ? FP32_QNAN : in_result;
`else
    result   = in_result;
`endif
  end

endmodule

// File: rtl/fmul_result_buffer.sv
// Registered FIFO stage behind the single-precision multiplier with sticky exception flags.
// Optional NaN canonicalisation is selected by the FMUL_NAN_CANON_EN macro.
module fmul_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 sticky_flags,
  input  logic                       flags_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    fmul_prod_t       prod;
    logic [TAG_W-1:0] tag;
  } entry_t;

  fmul_flags_t       cls_flags;
  logic [31:0]       cls_result;
  entry_t            entry_next;
  entry_t            head;
  entry_t            rd_entries [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [2:0]        sticky_reg, sticky_next;
  logic              push, pop;

  fmul_flag_classify u_classify (
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .flags        (cls_flags),
    .result       (cls_result)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
  endfunction

  assign in_ready     = (count_reg < CNT_W'(DEPTH));
  assign out_valid    = (count_reg != '0);
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign count        = count_reg;
  assign sticky_flags = sticky_reg;

  always_comb begin
    entry_next.prod.result = cls_result;
    entry_next.prod.flags  = cls_flags;
    entry_next.tag         = in_tag;

    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;

    // A push in the clearing cycle still leaves its own flags behind.
    sticky_next = sticky_reg;
    if (push)
      sticky_next = (flags_clr ? 3'b000 : sticky_reg) | cls_flags;
    else if (flags_clr)
      sticky_next = 3'b000;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      sticky_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      sticky_reg <= sticky_next;
    end
  end

  // Payload storage needs no reset: the outputs are masked whenever count is zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t entry_reg;
      always_ff @(posedge CLK) begin
        if (push && (wr_ptr_reg == PTR_W'(gi)))
          entry_reg <= entry_next;
      end
      assign rd_entries[gi] = entry_reg;
    end
  endgenerate

  assign head = rd_entries[rd_ptr_reg];

  always_comb begin
    out_result = '0;
    out_tag    = '0;
    out_flags  = '0;
    if (out_valid) begin
      out_result = head.prod.result;
      out_tag    = head.tag;
      out_flags  = head.prod.flags;
    end
  end

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Self-checking bench for fmul_result_buffer: directed steps then random traffic against a queue model.
// Expected NaN payloads follow the FMUL_NAN_CANON_EN macro like the design.
module tb_fmul_result_buffer;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_overflow;
  logic             in_underflow;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;
  logic [2:0]       sticky_flags;
  logic             flags_clr;
  logic [1:0]       count;

  always #5 CLK = ~CLK;

  fmul_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .count        (count)
  );

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       fl;
  } exp_t;

  exp_t       model_q[$];
  logic [2:0] model_sticky = 3'b000;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  // NaN: biased exponent all ones and a non-zero fraction.
  function automatic bit is_nan(logic [31:0] r);
    int unsigned e, f;
    e = (r / (2**23)) % 256;
    f = r % (2**23);
    return (e == 255) && (f != 0);
  endfunction

  function automatic exp_t make_entry(logic [31:0] r, logic of, logic uf, logic [TAG_W-1:0] t);
    exp_t e;
    e.res = r;
`ifdef FMUL_NAN_CANON_EN
    if (is_nan(r)) e.res = 32'h7FC00000;
`endif
    e.tag = t;
    e.fl  = {is_nan(r), of, uf};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic check_all();
    exp_t h;
    bit   ev;
    ev = (model_q.size() != 0);
    h  = '{res: 32'd0, tag: '0, fl: 3'b000};
    if (ev) h = model_q[0];
    check("out_valid",    32'(out_valid),    32'(ev));
    check("count",        32'(count),        32'(model_q.size()));
    check("in_ready",     32'(in_ready),     32'(model_q.size() < DEPTH));
    check("out_result",   out_result,        h.res);
    check("out_tag",      32'(out_tag),      32'(h.tag));
    check("out_flags",    32'(out_flags),    32'(h.fl));
    check("sticky_flags", 32'(sticky_flags), 32'(model_sticky));
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic of, input logic uf,
                       input logic [TAG_W-1:0] t, input logic ordy, input logic clr);
    in_valid = v; in_result = r; in_overflow = of; in_underflow = uf;
    in_tag = t; out_ready = ordy; flags_clr = clr;
  endtask

  // One clock: predict push/pop from pre-edge state, advance, update model, compare.
  task automatic cycle();
    bit   push, pop;
    exp_t e;
    push = in_valid && (model_q.size() < DEPTH);
    pop  = out_ready && (model_q.size() != 0);
    e    = make_entry(in_result, in_overflow, in_underflow, in_tag);
    @(posedge CLK);
    #1;
    if (pop) void'(model_q.pop_front());
    if (push) begin
      model_q.push_back(e);
      model_sticky = (flags_clr ? 3'b000 : model_sticky) | e.fl;
    end else if (flags_clr) begin
      model_sticky = 3'b000;
    end
    $display("cyc push=%0b pop=%0b count=%0d out_valid=%0b out_tag=%0d out_result=%h sticky=%b",
             push, pop, count, out_valid, out_tag, out_result, sticky_flags);
    check_all();
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 32'd0, 0, 0, '0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single pass
    drive(1, 32'h460DB066, 0, 0, 4'd3, 0, 0); cycle();
    check("single_result", out_result, 32'h460DB066);
    check("single_tag", 32'(out_tag), 32'd3);
    drive(0, 32'd0, 0, 0, '0, 1, 0); cycle();
    check("single_drained", 32'(count), 32'd0);

    // Full / backpressure; third push coincides with a pop and must be refused
    drive(1, 32'h426947AF, 0, 0, 4'd1, 0, 0); cycle();
    drive(1, 32'hC26947AF, 0, 0, 4'd2, 0, 0); cycle();
    check("full_count", 32'(count), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 32'h3F800000, 0, 0, 4'd5, 1, 0); cycle();
    check("full_no_push", 32'(count), 32'd1);
    check("drain_order", out_result, 32'hC26947AF);
    drive(0, 32'd0, 0, 0, '0, 1, 0); cycle();

    // NaN classification
    drive(1, 32'hFFFFFFFF, 0, 0, 4'd7, 0, 0); cycle();
    check("nan_nv", 32'(out_flags[2]), 32'd1);
    check("nan_sticky_nv", 32'(sticky_flags[2]), 32'd1);
`ifdef FMUL_NAN_CANON_EN
    check("nan_result", out_result, 32'h7FC00000);
`else
    check("nan_result", out_result, 32'hFFFFFFFF);
`endif
    drive(1, 32'h7F800000, 0, 0, 4'd8, 1, 0); cycle();
    check("inf_not_nan", 32'(out_flags), 32'd0);
    drive(0, 32'd0, 0, 0, '0, 1, 0); cycle();

    // Sticky flags
    drive(0, 32'd0, 0, 0, '0, 1, 1); cycle();
    check("sticky_cleared", 32'(sticky_flags), 32'd0);
    drive(1, 32'h7F7FFFFF, 1, 0, 4'd9, 1, 0); cycle();
    check("sticky_of", 32'(sticky_flags), 32'b010);
    drive(1, 32'h00000001, 0, 1, 4'd10, 1, 1); cycle();
    check("sticky_clr_push", 32'(sticky_flags), 32'b001);
    drive(0, 32'd0, 0, 0, '0, 1, 0); cycle();

    // Asynchronous reset with two entries held
    drive(1, 32'h40000000, 1, 0, 4'd11, 0, 0); cycle();
    drive(1, 32'h40400000, 0, 0, 4'd12, 0, 0); cycle();
    drive(0, 32'd0, 0, 0, '0, 0, 0);
    #2;
    nRST = 1'b0;
    #1;
    model_q.delete();
    model_sticky = 3'b000;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming: tags 0..9, one product per cycle after the first
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h3F800000 + 32'(i), 0, 0, TAG_W'(i), 1, 0);
      cycle();
      check("stream_count", 32'(count), 32'd1);
      check("stream_tag", 32'(out_tag), 32'(i));
    end
    drive(0, 32'd0, 0, 0, '0, 1, 0); cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFF;
      if ($urandom_range(0, 7) == 0) r[22:0] = 23'd0;
      drive(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            TAG_W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
